// File: rtl/mem_port_arbiter_pkg.sv
// Shared parameters, FSM encoding and helpers for the two-port memory arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_BITS_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam int ROM_SIZE_DEF  = 1024;

  localparam logic [7:0] VIOL_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == VIOL_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: the port not granted last wins a tie; port 0
// is favoured after reset.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt0,
  output logic gnt1
);

  // prio = 1 means port 1 wins a tie
  logic prio;

  always_comb begin
    gnt0 = req0 && (!req1 || !prio);
    gnt1 = req1 && (!req0 || prio);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (take && (gnt0 || gnt1)) begin
      prio <= gnt0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two requesters share one synchronous memory: round-robin arbitration,
// fixed three-cycle access (IDLE/ACCESS/RESP) and blocking of ROM writes.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ROM_SIZE  = ROM_SIZE_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 rq0_req,
  input  logic                 rq0_we,
  input  logic [ADDR_BITS-1:0] rq0_addr,
  input  logic [DATA_BITS-1:0] rq0_wdata,
  output logic                 rq0_ack,
  output logic [DATA_BITS-1:0] rq0_rdata,
  output logic                 rq0_err,
  input  logic                 rq1_req,
  input  logic                 rq1_we,
  input  logic [ADDR_BITS-1:0] rq1_addr,
  input  logic [DATA_BITS-1:0] rq1_wdata,
  output logic                 rq1_ack,
  output logic [DATA_BITS-1:0] rq1_rdata,
  output logic                 rq1_err,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic [7:0]           viol_cnt
);

  // Handshake: a requester raises req with we/addr/wdata stable and holds it
  // until a one-cycle ack; rdata/err are meaningful only in that ack cycle.
  // The requester drops or renews req on the edge after ack.

  localparam logic [ADDR_BITS:0] ROM_LIMIT = (ADDR_BITS+1)'(ROM_SIZE);

  state_t                 state;
  state_t                 state_next;
  logic                   gnt0;
  logic                   gnt1;
  logic                   take;
  logic                   lat_port;
  logic                   lat_we;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [DATA_BITS-1:0]   lat_wdata;
  logic                   blocked;
  logic [7:0]             viol_q;

  assign take = (state == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .clk   (CLK),
    .reset (RESET),
    .req0  (rq0_req),
    .req1  (rq1_req),
    .take  (take),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign blocked   = lat_we && ({1'b0, lat_addr} < ROM_LIMIT);
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign viol_cnt  = viol_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    rq0_ack    = 1'b0;
    rq0_err    = 1'b0;
    rq0_rdata  = '0;
    rq1_ack    = 1'b0;
    rq1_err    = 1'b0;
    rq1_rdata  = '0;
    case (state)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A blocked ROM write never reaches the memory.
        mem_cs     = !blocked;
        mem_we     = lat_we && !blocked;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
        if (lat_port) begin
          rq1_ack   = 1'b1;
          rq1_err   = blocked;
          rq1_rdata = lat_we ? '0 : mem_rdata;
        end else begin
          rq0_ack   = 1'b1;
          rq0_err   = blocked;
          rq0_rdata = lat_we ? '0 : mem_rdata;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      viol_q    <= 8'd0;
    end else begin
      if (state == ST_IDLE && (gnt0 || gnt1)) begin
        lat_port  <= gnt1;
        lat_we    <= gnt1 ? rq1_we    : rq0_we;
        lat_addr  <= gnt1 ? rq1_addr  : rq0_addr;
        lat_wdata <= gnt1 ? rq1_wdata : rq0_wdata;
      end
      if (state == ST_ACCESS && blocked) begin
        viol_q <= sat_inc(viol_q);
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL come from param.vh: ADDR_BITS (default 16, address width), DATA_BITS (default 8, data width), ROM_SIZE (first RAM address; addresses below it are ROM).
REQ-003 Ports SHALL be as listed below; N = 0, 1 for both requester ports.
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- rqN_req  in  1  requester N access request; held until rqN_ack.
- rqN_we  in  1  1 = write, 0 = read; stable while rqN_req is high.
- rqN_addr  in  ADDR_BITS  access address; stable while rqN_req is high.
- rqN_wdata  in  DATA_BITS  write data; stable while rqN_req is high.
- rqN_ack  out  1  one-cycle completion pulse.
- rqN_rdata  out  DATA_BITS  read data; valid only while rqN_ack is high.
- rqN_err  out  1  ROM-write violation; valid only while rqN_ack is high.
- mem_cs  out  1  memory chip select.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_BITS  memory address.
- mem_wdata  out  DATA_BITS  memory write data.
- mem_rdata  in  DATA_BITS  memory read data; valid one cycle after mem_cs=1 with mem_we=0.
- viol_cnt  out  8  saturating count of blocked ROM writes.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-005 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-006 In IDLE with any request, the FSM SHALL latch the winner's we/addr/wdata and go to ACCESS.
REQ-007 With one request, that port SHALL win.
REQ-008 With both requests, the port not granted last SHALL win (round-robin); after reset, port 0 SHALL have priority.
REQ-009 In ACCESS, the block SHALL drive mem_cs=1, mem_we=latched we, and mem_addr/mem_wdata from the latch for exactly one cycle, then go to RESP.
REQ-010 In RESP, the block SHALL pulse the winner's ack for one cycle with rdata=mem_rdata (reads) or 0 (writes), then go to IDLE.
REQ-011 Outside ACCESS, mem_cs and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold the latched values.
REQ-012 Latency SHALL be fixed: req sampled high in IDLE at cycle 0 -> mem_cs at cycle 1 -> ack at cycle 2; peak throughput is one access per 3 cycles.
REQ-013 Requesters drop or renew req on the edge after ack; the IDLE cycle after RESP SHALL arbitrate afresh, so a requester holding req wins again only when the other is idle.
REQ-014 A write with latched addr < ROM_SIZE SHALL be blocked: ACCESS drives mem_cs=0, mem_we=0; RESP acks with err=1, rdata=0; viol_cnt increments, saturating at 255.
REQ-015 Reads of ROM addresses SHALL proceed normally with err=0.
REQ-016 The non-winning port's ack, err and rdata SHALL be 0 at all times.
REQ-017 A request arriving while busy SHALL wait, neither lost nor acked, until the next IDLE arbitration.

Reset
REQ-018 On RESET=1 at a rising edge, the block SHALL enter IDLE with mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, all ack/err/rdata=0, viol_cnt=0, priority=port 0.
REQ-019 A transaction in ACCESS or RESP when RESET is sampled SHALL be abandoned without ack; the requester re-issues it.
REQ-020 The memory's own RESET is driven externally and is not sequenced by this block.

Structure
REQ-021 ADDR_BITS, DATA_BITS, ROM_SIZE and the FSM state encodings SHALL reside in the shared param.vh.
REQ-022 The two-input round-robin grant logic (priority pointer and grant) SHALL be one sub-module, rr_arb2; everything else SHALL be in mem_port_arbiter.

Verification
REQ-023 The bench SHALL cover these directed scenarios, with ROM_SIZE=1024:
- Port 0 reads addr 5 alone -> mem_cs at cycle 1, rq0_ack at cycle 2, rq0_rdata = ROM[5], rq0_err=0.
- Port 1 writes 0x5A to 1027, then reads 1027 -> second ack returns rdata=0x5A.
- Both ports request reads at cycle 0 after reset -> port 0 acks first at cycle 2; port 1 is granted at cycle 3 and acks at cycle 5.
- Port 0 writes 0xFF to addr 10 -> mem_cs stays 0; rq0_ack with err=1; viol_cnt 0->1; a later read of addr 10 returns the original ROM value.
- RESET asserted in the ACCESS cycle -> no ack; all outputs 0 next cycle; a re-issued request completes normally.
- 260 blocked ROM writes -> viol_cnt saturates at 255.
